max_pool_2x2_stream: RTL



---
 rtl/max_pool_2x2_stream_if.sv | 29 ++
 rtl/max_pool_2x2_stream.sv | 139 +++++++++++++
 2 files changed

// File: rtl/max_pool_2x2_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_2x2_stream_if
// Description : Activation-in / pooled-out stream bundle for the 2x2 pooler.
// Revision    : 1.0 - initial release
// ============================================================================
interface max_pool_2x2_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  out_last_o;
    logic                  frame_done_o;

    modport master (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, out_last_o, frame_done_o
    );

    modport slave (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, out_last_o, frame_done_o
    );
endinterface
`default_nettype wire

// File: rtl/max_pool_2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_2x2_stream
// Description : Streaming 2x2 stride-2 signed max pooling with a one-row
//               buffer of horizontal pair maxima.
// Revision    : 1.0 - initial release
// ============================================================================
module max_pool_2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_W       = 26,
    parameter int IN_H       = 26
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             clear_i,
    max_pool_2x2_stream_if.slave  bus
);
    localparam int c_COL_W = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int c_ROW_W = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int c_HALF  = IN_W / 2;
    localparam int c_K_W   = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IN_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IN_H - 1);

    generate
        if ((IN_W < 2) || ((IN_W % 2) != 0)) begin : g_bad_in_w
            $error("max_pool_2x2_stream: IN_W must be even and >= 2");
        end
        if ((IN_H < 2) || ((IN_H % 2) != 0)) begin : g_bad_in_h
            $error("max_pool_2x2_stream: IN_H must be even and >= 2");
        end
    endgenerate

    function automatic logic signed [DATA_WIDTH-1:0] f_smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [c_COL_W-1:0]           r_col_cnt;
    logic [c_ROW_W-1:0]           r_row_cnt;
    logic signed [DATA_WIDTH-1:0] r_hold;
    logic signed [DATA_WIDTH-1:0] r_rowbuf [c_HALF];
    logic [DATA_WIDTH-1:0]        r_out_data;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic                         r_frame_done;

    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_emit;
    logic                         w_odd_col;
    logic                         w_odd_row;
    logic                         w_col_last;
    logic                         w_row_last;
    logic                         w_load;
    logic                         w_buf_wr;
    logic [c_K_W-1:0]             w_k;
    logic signed [DATA_WIDTH-1:0] w_pix;
    logic signed [DATA_WIDTH-1:0] w_pair;
    logic signed [DATA_WIDTH-1:0] w_above;
    logic signed [DATA_WIDTH-1:0] w_pool;

    // A stalled output blocks intake so no pooled value is ever overwritten
    assign w_in_ready = !clear_i && (!r_out_valid || bus.out_ready_i);
    assign w_accept   = bus.in_valid_i && w_in_ready;
    assign w_emit     = r_out_valid && bus.out_ready_i;

    assign w_odd_col  = r_col_cnt[0];
    assign w_odd_row  = r_row_cnt[0];
    assign w_col_last = (r_col_cnt == c_COL_LAST);
    assign w_row_last = (r_row_cnt == c_ROW_LAST);
    assign w_k        = c_K_W'(r_col_cnt >> 1);

    assign w_pix      = bus.in_data_i;
    assign w_pair     = f_smax(r_hold, w_pix);
    assign w_above    = r_rowbuf[w_k];
    assign w_pool     = f_smax(w_above, w_pair);

    assign w_load     = w_accept && w_odd_col && w_odd_row;
    assign w_buf_wr   = w_accept && w_odd_col && !w_odd_row;

    assign bus.in_ready_o   = w_in_ready;
    assign bus.out_data_o   = r_out_data;
    assign bus.out_valid_o  = r_out_valid;
    assign bus.out_last_o   = r_out_last;
    assign bus.frame_done_o = r_frame_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_hold       <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (clear_i) begin
            // Frame restart keeps the last data word visible but drops it
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_hold       <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_emit && r_out_last;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
                if (!w_odd_col) begin
                    r_hold <= w_pix;
                end
            end
            if (w_load) begin
                r_out_data  <= w_pool;
                r_out_valid <= 1'b1;
                r_out_last  <= w_row_last && w_col_last;
            end else if (w_emit) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Row buffer needs no reset: every entry is written on an even row
    // before the odd row reads it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_buf_wr) begin
            r_rowbuf[w_k] <= w_pair;
        end
    end

endmodule
`default_nettype wire
